pmu_dvfs_governor: RTL

//  Upstream request source for power_manager. Measures bus activity over fixed cycle windows
//  and issues one-cycle level-change requests (flag + level) on hysteresis thresholds.

---
 rtl/pmu_pkg.sv | 25 ++
 rtl/pmu_activity_window.sv | 42 ++++
 rtl/pmu_dvfs_governor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pmu_pkg.sv
// Shared types and helpers for the PMU DVFS governor: level width, FSM encoding,
// power-mode codes and the level clamp.
package pmu_pkg;

  localparam int LEVEL_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    HOLDOFF = 2'd3
  } gov_state_e;

  localparam logic MODE_RUN   = 1'b0;
  localparam logic MODE_SLEEP = 1'b1;

  function automatic int clamp_level(input int lvl, input int lo, input int hi);
    int r;
    r = lvl;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    clamp_level = r;
  endfunction

endpackage

// File: rtl/pmu_activity_window.sv
// Fixed-length activity window: counts 2**WINDOW_LOG2 cycles and the busy strobes
// inside them, with the busy count saturating at the window length.
module pmu_activity_window #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 busy,
  output logic                 window_done,
  output logic [WINDOW_LOG2:0] act_count
);

  localparam int ACT_W = WINDOW_LOG2 + 1;
  localparam logic [ACT_W-1:0] ACT_MAX = ACT_W'(1) << WINDOW_LOG2;

  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [ACT_W-1:0]       act_cnt;

  function automatic logic [ACT_W-1:0] sat_inc(input logic [ACT_W-1:0] v, input logic inc);
    if (inc && (v != ACT_MAX))
      sat_inc = v + ACT_W'(1);
    else
      sat_inc = v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      win_cnt <= '0;
      act_cnt <= '0;
    end else if (run) begin
      win_cnt <= win_cnt + WINDOW_LOG2'(1);
      act_cnt <= sat_inc(act_cnt, busy);
    end
  end

  // The last window cycle still counts its own busy sample before DECIDE reads it.
  assign window_done = run && (win_cnt == '1);
  assign act_count   = act_cnt;

endmodule

// File: rtl/pmu_dvfs_governor.sv
// Activity-driven DVFS governor feeding power_manager level/mode change requests.
// Optional sleep-mode requests are built when PMU_GOVERNOR_SLEEP_EN is defined.
module pmu_dvfs_governor
  import pmu_pkg::*;
#(
  parameter int WINDOW_LOG2   = 8,
  parameter int LEVEL_W       = pmu_pkg::LEVEL_W,
  parameter int UP_THRESH     = 192,
  parameter int DOWN_THRESH   = 64,
  parameter int HOLD_WINDOWS  = 2,
  parameter int MIN_LEVEL     = 0,
  parameter int MAX_LEVEL     = 7,
  parameter int RESET_LEVEL   = 5,
  parameter int SLEEP_WINDOWS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               busy,
  input  logic               force_flag,
  input  logic [LEVEL_W-1:0] force_level,
  output logic               change_level_flag,
  output logic [LEVEL_W-1:0] change_level,
  output logic [LEVEL_W-1:0] current_level,
  output logic               change_power_mode_flag,
  output logic               change_power_mode
);

  localparam int HOLD_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;

  if (DOWN_THRESH >= UP_THRESH) begin : g_chk_thresh
    $error("pmu_dvfs_governor: DOWN_THRESH must be below UP_THRESH");
  end
  if (SLEEP_WINDOWS < 1) begin : g_chk_sleep
    $error("pmu_dvfs_governor: SLEEP_WINDOWS must be at least 1");
  end

  gov_state_e state, state_nxt;

  logic                 flag_q;
  logic [LEVEL_W-1:0]   level_q;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 force_pend;
  logic [LEVEL_W-1:0]   pend_lvl;

  logic                 window_done;
  logic [WINDOW_LOG2:0] act_count;
  logic                 win_run, win_clear, win_busy;

  logic [LEVEL_W-1:0]   force_lvl_c, force_tgt, step_lvl;
  logic                 take_force, up_ok, dn_ok, decide_req, hold_last;

  pmu_activity_window #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_window (
    .clk        (clk),
    .reset      (reset),
    .clear      (win_clear),
    .run        (win_run),
    .busy       (win_busy),
    .window_done(window_done),
    .act_count  (act_count)
  );

  always_comb begin
    force_lvl_c = LEVEL_W'(clamp_level(int'(force_level), MIN_LEVEL, MAX_LEVEL));
    // A force landing on a pulse cycle is parked so pulses never touch.
    take_force  = (force_flag || force_pend) && !flag_q;
    force_tgt   = force_flag ? force_lvl_c : pend_lvl;
    up_ok       = (int'(act_count) >= UP_THRESH) && (int'(level_q) < MAX_LEVEL);
    dn_ok       = (int'(act_count) <= DOWN_THRESH) && (int'(level_q) > MIN_LEVEL);
    decide_req  = (state == DECIDE) && enable && !take_force && (up_ok || dn_ok);
    step_lvl    = up_ok ? (level_q + LEVEL_W'(1)) : (level_q - LEVEL_W'(1));
    hold_last   = (int'(hold_cnt) == HOLD_WINDOWS - 1);

    win_run   = (state == MEASURE) || (state == HOLDOFF);
    win_busy  = busy && (state == MEASURE);
    win_clear = (state == IDLE) || (state == DECIDE) || take_force || !enable;

    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = MEASURE;
      MEASURE: if (window_done) state_nxt = DECIDE;
      DECIDE:  state_nxt = (decide_req && (HOLD_WINDOWS > 0)) ? HOLDOFF : MEASURE;
      HOLDOFF: if (window_done && hold_last) state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
    if (take_force) state_nxt = (HOLD_WINDOWS > 0) ? HOLDOFF : MEASURE;
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      flag_q     <= 1'b0;
      level_q    <= LEVEL_W'(RESET_LEVEL);
      hold_cnt   <= '0;
      force_pend <= 1'b0;
    end else begin
      state  <= state_nxt;
      flag_q <= take_force || decide_req;
      if (take_force)
        level_q <= force_tgt;
      else if (decide_req)
        level_q <= step_lvl;
      if ((state == HOLDOFF) && !take_force) begin
        if (window_done) hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (force_flag && flag_q)
        force_pend <= 1'b1;
      else if (take_force)
        force_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (force_flag && flag_q) pend_lvl <= force_lvl_c;
  end

  assign change_level_flag = flag_q;
  assign change_level      = level_q;
  assign current_level     = level_q;

`ifdef PMU_GOVERNOR_SLEEP_EN
  localparam int IDLE_W = (SLEEP_WINDOWS > 1) ? $clog2(SLEEP_WINDOWS) : 1;

  logic [IDLE_W-1:0] idle_cnt;
  logic              mode_q, mode_flag_q;
  logic              window_eval, idle_win, go_sleep, wake;

  always_comb begin
    window_eval = (state == DECIDE) && enable && !take_force;
    idle_win    = (act_count == '0) && (level_q == LEVEL_W'(MIN_LEVEL));
    go_sleep    = (mode_q == MODE_RUN) && window_eval && idle_win &&
                  (int'(idle_cnt) == SLEEP_WINDOWS - 1);
    wake        = (mode_q == MODE_SLEEP) &&
                  (take_force || (window_eval && (act_count != '0)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt    <= '0;
      mode_q      <= MODE_RUN;
      mode_flag_q <= 1'b0;
    end else begin
      mode_flag_q <= go_sleep || wake;
      if (go_sleep)
        mode_q <= MODE_SLEEP;
      else if (wake)
        mode_q <= MODE_RUN;
      if (take_force || go_sleep || (window_eval && !idle_win))
        idle_cnt <= '0;
      else if (window_eval && (mode_q == MODE_RUN))
        idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign change_power_mode_flag = mode_flag_q;
  assign change_power_mode      = mode_q;
`else
  assign change_power_mode_flag = 1'b0;
  assign change_power_mode      = MODE_RUN;
`endif

endmodule
